// File: rtl/fwd_hazard_sb.sv
// ============================================================================
// Module   : fwd_hazard_sb
// Purpose  : ID-stage forwarding and hazard scoreboard. Tracks in-flight GPR
//            writes through DEPTH post-ID stages (0=EX, 1=MEM, 2=WB), each
//            tagged with the stage at whose end its result exists. Produces
//            per-read-port forward selects, a unified stall, and interlocks
//            HI/LO readers against a multi-cycle mult/div unit.
// Ports    : clk, rst_n (async active-low)
//            id_valid, id_rs_addr[NRP*RW], id_rs_used[NRP]   - ID read side
//            id_wr_en, id_wr_addr[RW], id_rdy_stage[SELW]    - ID write side
//            id_is_md, id_uses_hilo, flush                   - control
//            fwd_sel[NRP*SELW] (0=regfile, k+1=stage k tap), stall,
//            hilo_stall, md_busy
//            stat_stall_cnt[32], stat_fwd_cnt[32] (only with the option)
// Option   : define FWD_HAZARD_SB_STATS_EN to add saturating stall/forward
//            event counters.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fwd_hazard_sb #(
  parameter int NRP    = 2,
  parameter int DEPTH  = 3,
  parameter int RW     = 5,
  parameter int MD_LAT = 32,
  parameter int SELW   = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [NRP*RW-1:0] id_rs_addr,
  input  logic [NRP-1:0]    id_rs_used,
  input  logic              id_wr_en,
  input  logic [RW-1:0]     id_wr_addr,
  input  logic [SELW-1:0]   id_rdy_stage,
  input  logic              id_is_md,
  input  logic              id_uses_hilo,
  input  logic              flush,
  output logic [NRP*SELW-1:0] fwd_sel,
  output logic              stall,
  output logic              hilo_stall,
  output logic              md_busy
`ifdef FWD_HAZARD_SB_STATS_EN
  ,
  output logic [31:0]       stat_stall_cnt,
  output logic [31:0]       stat_fwd_cnt
`endif
);

  localparam int c_cntW = $clog2(MD_LAT + 1);
  localparam logic [c_cntW-1:0] c_mdLoad = c_cntW'(MD_LAT);

  // Scoreboard entries: index k is the instruction currently in stage k.
  logic [DEPTH-1:0] r_entV;
  logic [RW-1:0]    r_entAddr [DEPTH];
  logic [SELW-1:0]  r_entRdy  [DEPTH];
  logic [c_cntW-1:0] r_mdCnt;

  logic             w_acc;
  logic [NRP-1:0]   w_hazVec;
`ifdef FWD_HAZARD_SB_STATS_EN
  logic [NRP-1:0]   w_fwdOk;
`endif

  // --------------------------------------------------------------------------
  // Per-port lookup. The loop runs oldest to youngest so the youngest
  // matching entry is the last assignment and therefore wins.
  // --------------------------------------------------------------------------
  for (genvar p = 0; p < NRP; p++) begin : g_port
    logic [RW-1:0]   w_addr;
    logic            w_active;
    logic [SELW-1:0] w_sel;
    logic            w_haz;

    assign w_addr   = id_rs_addr[p*RW +: RW];
    assign w_active = id_valid & id_rs_used[p] & (w_addr != '0);

    always_comb begin
      w_sel = '0;
      w_haz = 1'b0;
      for (int k = DEPTH - 1; k >= 0; k--) begin
        if (w_active && r_entV[k] && (r_entAddr[k] == w_addr)) begin
          w_sel = SELW'(k + 1);
          // Result only exists once the producer has finished its ready stage.
          w_haz = (SELW'(k) < r_entRdy[k]);
        end
      end
    end

    assign fwd_sel[p*SELW +: SELW] = w_sel;
    assign w_hazVec[p]             = w_haz;
`ifdef FWD_HAZARD_SB_STATS_EN
    assign w_fwdOk[p]              = (w_sel != '0) & ~w_haz;
`endif
  end

  assign md_busy    = (r_mdCnt != '0);
  assign hilo_stall = id_valid & id_uses_hilo & md_busy;
  assign stall      = hilo_stall | (|w_hazVec);
  // Flush dominates: a squashed instruction neither allocates nor starts mult/div.
  assign w_acc      = id_valid & ~stall & ~flush;

  // --------------------------------------------------------------------------
  // Entry shift. The stages behind ID never stall, so entries advance every
  // edge; a stalled or squashed ID inserts a bubble at entry 0.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_entV <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        r_entAddr[k] <= '0;
        r_entRdy[k]  <= '0;
      end
    end else begin
      r_entV[0]    <= w_acc & id_wr_en & (id_wr_addr != '0);
      r_entAddr[0] <= id_wr_addr;
      r_entRdy[0]  <= id_rdy_stage;
      for (int k = 1; k < DEPTH; k++) begin
        r_entV[k]    <= r_entV[k-1];
        r_entAddr[k] <= r_entAddr[k-1];
        r_entRdy[k]  <= r_entRdy[k-1];
      end
    end
  end

  // Mult/div busy counter; a flush in ID does not abort a running operation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mdCnt <= '0;
    end else if (w_acc && id_is_md) begin
      r_mdCnt <= c_mdLoad;
    end else if (r_mdCnt != '0) begin
      r_mdCnt <= r_mdCnt - 1'b1;
    end
  end

`ifdef FWD_HAZARD_SB_STATS_EN
  localparam int c_incW = $clog2(NRP + 1);

  logic [c_incW-1:0] w_fwdInc;
  logic [32:0]       w_fwdSum;

  always_comb begin
    w_fwdInc = '0;
    for (int p = 0; p < NRP; p++) begin
      w_fwdInc = w_fwdInc + c_incW'(w_fwdOk[p]);
    end
  end

  // One extra bit catches the wrap so the counter can pin at all-ones.
  assign w_fwdSum = {1'b0, stat_fwd_cnt} + 33'(w_fwdInc);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_stall_cnt <= '0;
      stat_fwd_cnt   <= '0;
    end else begin
      if (stall && (stat_stall_cnt != '1)) begin
        stat_stall_cnt <= stat_stall_cnt + 32'd1;
      end
      stat_fwd_cnt <= w_fwdSum[32] ? '1 : w_fwdSum[31:0];
    end
  end
`endif

endmodule

`default_nettype wire
